// File: rtl/tcm_banked_dp_if.sv
// Request/response bundle for one TCM port (fetch or LSU).
//   master: drives req/addr/we/be/wdata, receives gnt/rvalid/rdata
//   slave : the TCM side
// gnt is combinational in the current cycle. rdata is zero whenever rvalid is low.
interface tcm_banked_dp_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tcm_banked_dp.sv
// Dual-port banked tightly-coupled memory.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   p0    : fetch port (slave side of tcm_banked_dp_if)
//   p1    : LSU port   (slave side of tcm_banked_dp_if)
// Each bank is a single-port RAM with a 1-cycle read. When both ports hit the
// same bank, a 1-bit round-robin pointer picks the winner. The pointer moves to
// the loser only after a conflict. Read data is zero when not valid. OUT_REG=1
// adds one more output flop stage.
module tcm_banked_dp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8192,
  parameter int unsigned BANK_DEPTH = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH*DATA_WIDTH/8),
  parameter bit          INTERLEAVE = 1'b0,
  parameter bit          OUT_REG    = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tcm_banked_dp_if.slave p0,
  tcm_banked_dp_if.slave p1
);
  localparam int unsigned BANK_NUM = DEPTH / BANK_DEPTH;
  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned OFFS     = $clog2(BYTES);
  localparam int unsigned WORD_AW  = $clog2(DEPTH);
  localparam int unsigned ROW_W    = $clog2(BANK_DEPTH);
  localparam int unsigned BANK_AW  = $clog2(BANK_NUM);
  localparam int unsigned BSEL_W   = (BANK_AW > 0) ? BANK_AW : 1;

  typedef logic [BSEL_W-1:0] bsel_t;
  typedef logic [ROW_W-1:0]  row_t;

  function automatic bsel_t bank_of(input logic [ADDR_WIDTH-1:0] a);
    logic [WORD_AW-1:0] w;
    w = WORD_AW'(a >> OFFS);
    if (BANK_NUM == 1) return '0;
    return INTERLEAVE ? BSEL_W'(w) : BSEL_W'(w >> ROW_W);
  endfunction

  function automatic row_t row_of(input logic [ADDR_WIDTH-1:0] a);
    logic [WORD_AW-1:0] w;
    w = WORD_AW'(a >> OFFS);
    return INTERLEAVE ? ROW_W'(w >> BANK_AW) : ROW_W'(w);
  endfunction

  logic [1:0]            req, we, gnt;
  logic [BYTES-1:0]      be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  bsel_t                 bank  [2];
  row_t                  row   [2];
  logic                  conflict;
  logic                  rr_q;

  always_comb begin
    req      = {p1.req, p0.req};
    we       = {p1.we, p0.we};
    be[0]    = p0.be;
    be[1]    = p1.be;
    wdata[0] = p0.wdata;
    wdata[1] = p1.wdata;
    bank[0]  = bank_of(p0.addr);
    bank[1]  = bank_of(p1.addr);
    row[0]   = row_of(p0.addr);
    row[1]   = row_of(p1.addr);
    conflict = req[0] && req[1] && (bank[0] == bank[1]);
    gnt[0]   = !rst_i && req[0] && (!conflict || !rr_q);
    gnt[1]   = !rst_i && req[1] && (!conflict ||  rr_q);
  end

  assign p0.gnt = gnt[0];
  assign p1.gnt = gnt[1];

  // After a conflict the pointer always names the port that just lost.
  always_ff @(posedge clk_i) begin
    if (rst_i)         rr_q <= 1'b0;
    else if (conflict) rr_q <= ~rr_q;
  end

  logic [DATA_WIDTH-1:0] bank_rdata [BANK_NUM];

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    localparam bsel_t BID = bsel_t'(b);
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  hit0, hit1, wr;
    row_t                  ra;
    logic [BYTES-1:0]      wbe;
    logic [DATA_WIDTH-1:0] wd;

    // Arbitration never grants both ports into the same bank.
    always_comb begin
      hit0 = gnt[0] && (bank[0] == BID);
      hit1 = gnt[1] && (bank[1] == BID);
      ra   = hit1 ? row[1]   : row[0];
      wr   = hit1 ? we[1]    : we[0];
      wbe  = hit1 ? be[1]    : be[0];
      wd   = hit1 ? wdata[1] : wdata[0];
    end

    always_ff @(posedge clk_i) begin
      if (hit0 || hit1) begin
        if (wr) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (wbe[i]) mem[ra][i*8 +: 8] <= wd[i*8 +: 8];
          end
        end else begin
          rd_q <= mem[ra];
        end
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  logic [1:0]            rd_pend_q;
  bsel_t                 rd_bank_q [2];
  logic [DATA_WIDTH-1:0] mux_data  [2];
  logic [1:0]            src_v;
  logic [DATA_WIDTH-1:0] src_d     [2];
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata     [2];

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_pend_q <= '0;
    else       rd_pend_q <= gnt & ~we;
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (gnt[p]) rd_bank_q[p] <= bank[p];
    end
  end

  always_comb begin
    mux_data[0] = bank_rdata[rd_bank_q[0]];
    mux_data[1] = bank_rdata[rd_bank_q[1]];
  end

  if (OUT_REG) begin : g_out_reg
    logic [1:0]            ov_q;
    logic [DATA_WIDTH-1:0] od_q [2];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ov_q    <= '0;
        od_q[0] <= '0;
        od_q[1] <= '0;
      end else begin
        ov_q    <= rd_pend_q;
        od_q[0] <= rd_pend_q[0] ? mux_data[0] : '0;
        od_q[1] <= rd_pend_q[1] ? mux_data[1] : '0;
      end
    end
    always_comb begin
      src_v    = ov_q;
      src_d[0] = od_q[0];
      src_d[1] = od_q[1];
    end
  end else begin : g_out_comb
    always_comb begin
      src_v    = rd_pend_q;
      src_d[0] = mux_data[0];
      src_d[1] = mux_data[1];
    end
  end

  // Gating with rst_i hides a response still in the pipeline during the
  // reset cycle. That response is dropped, not delivered late.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rvalid[p] = src_v[p] && !rst_i;
      rdata[p]  = rvalid[p] ? src_d[p] : '0;
    end
  end

  assign p0.rvalid = rvalid[0];
  assign p0.rdata  = rdata[0];
  assign p1.rvalid = rvalid[1];
  assign p1.rdata  = rdata[1];
endmodule
